// File: rtl/uart_receiver_if.sv
// Byte handshake between uart_receiver (master) and its consumer (slave).
interface uart_receiver_if;
   logic [7:0] data_out;
   logic       data_out_valid;
   logic       data_out_ready;

   modport master (
      output data_out,
      output data_out_valid,
      input  data_out_ready
   );

   modport slave (
      input  data_out,
      input  data_out_valid,
      output data_out_ready
   );
endinterface

// File: rtl/uart_receiver.sv
// 8N1 UART receiver with a single-entry ready/valid output buffer and sticky overrun.
// Optional stop-bit checking is enabled by defining UART_RX_FRAMING_CHECK_EN.
module uart_receiver #(
   parameter int CLOCK_FREQ = 50_000_000,
   parameter int BAUD_RATE  = 115_200
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            serial_in,
   uart_receiver_if.master out_if,
   output logic            overrun,
   output logic            framing_error
);
   localparam int SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE;
   localparam int SAMPLE_TIME      = SYMBOL_EDGE_TIME / 2;
   localparam int CW               = (SYMBOL_EDGE_TIME > 1) ? $clog2(SYMBOL_EDGE_TIME) : 1;
   localparam logic [CW-1:0] SAMPLE_LAST = CW'(SAMPLE_TIME - 1);
   localparam logic [CW-1:0] SYMBOL_LAST = CW'(SYMBOL_EDGE_TIME - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP
   } state_t;

   state_t        state_q;
   logic [1:0]    rx_sync_q;
   logic [CW-1:0] clk_cnt_q;
   logic [2:0]    bit_idx_q;
   logic [7:0]    shift_q;
   logic [7:0]    data_out_q;
   logic          data_out_valid_q;
   logic          overrun_q;
   logic          rx;
   logic          transfer;
   logic          can_load;

   assign rx       = rx_sync_q[1];
   assign transfer = data_out_valid_q && out_if.data_out_ready;
   // A byte may enter the buffer when it is empty or being drained this cycle.
   assign can_load = !data_out_valid_q || transfer;

   assign out_if.data_out       = data_out_q;
   assign out_if.data_out_valid = data_out_valid_q;
   assign overrun               = overrun_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_sync_q <= 2'b11;
      end else begin
         rx_sync_q <= {rx_sync_q[0], serial_in};
      end
   end

`ifdef UART_RX_FRAMING_CHECK_EN
   logic framing_error_q;
   logic wait_high_q;
   assign framing_error = framing_error_q;
`else
   assign framing_error = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q          <= S_IDLE;
         clk_cnt_q        <= '0;
         bit_idx_q        <= '0;
         shift_q          <= '0;
         data_out_q       <= '0;
         data_out_valid_q <= 1'b0;
         overrun_q        <= 1'b0;
`ifdef UART_RX_FRAMING_CHECK_EN
         framing_error_q  <= 1'b0;
         wait_high_q      <= 1'b0;
`endif
      end else begin
`ifdef UART_RX_FRAMING_CHECK_EN
         framing_error_q <= 1'b0;
`endif
         if (transfer) begin
            data_out_valid_q <= 1'b0;
            overrun_q        <= 1'b0;
         end

         case (state_q)
            S_IDLE: begin
               clk_cnt_q <= '0;
               bit_idx_q <= '0;
`ifdef UART_RX_FRAMING_CHECK_EN
               // After a bad stop bit the line must return high before re-arming.
               if (rx) begin
                  wait_high_q <= 1'b0;
               end else if (!wait_high_q) begin
                  state_q <= S_START;
               end
`else
               if (!rx) begin
                  state_q <= S_START;
               end
`endif
            end

            S_START: begin
               if (clk_cnt_q == SAMPLE_LAST) begin
                  clk_cnt_q <= '0;
                  bit_idx_q <= '0;
                  state_q   <= rx ? S_IDLE : S_DATA;
               end else begin
                  clk_cnt_q <= clk_cnt_q + CW'(1);
               end
            end

            S_DATA: begin
               if (clk_cnt_q == SYMBOL_LAST) begin
                  clk_cnt_q          <= '0;
                  shift_q[bit_idx_q] <= rx;
                  bit_idx_q          <= bit_idx_q + 3'd1;
                  if (bit_idx_q == 3'd7) begin
                     state_q <= S_STOP;
                  end
               end else begin
                  clk_cnt_q <= clk_cnt_q + CW'(1);
               end
            end

            S_STOP: begin
               if (clk_cnt_q == SYMBOL_LAST) begin
                  clk_cnt_q <= '0;
                  state_q   <= S_IDLE;
`ifdef UART_RX_FRAMING_CHECK_EN
                  if (!rx) begin
                     framing_error_q <= 1'b1;
                     wait_high_q     <= 1'b1;
                  end else if (can_load) begin
                     data_out_q       <= shift_q;
                     data_out_valid_q <= 1'b1;
                  end else begin
                     overrun_q <= 1'b1;
                  end
`else
                  if (can_load) begin
                     data_out_q       <= shift_q;
                     data_out_valid_q <= 1'b1;
                  end else begin
                     overrun_q <= 1'b1;
                  end
`endif
               end else begin
                  clk_cnt_q <= clk_cnt_q + CW'(1);
               end
            end

            default: begin
               state_q   <= S_IDLE;
               clk_cnt_q <= '0;
            end
         endcase
      end
   end
endmodule
